// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the N-port memory-bus arbiter.
// Imported by the pick logic and the arbiter top.
package mem_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Low bit of port idx's field inside a packed per-port bus
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/mem_arb_n_arb_pick.sv
// Winner selection: request minus exclude mask, searched either
// round-robin from ptr+1 or from port 0 upward (fixed priority).
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int RR     = ARB_RR,
    parameter int PW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [NPORTS-1:0] i_excl,
    input  logic [PW-1:0]     i_ptr,
    output logic [NPORTS-1:0] o_win,
    output logic [PW-1:0]     o_idx,
    output logic              o_any
);

    logic [NPORTS-1:0] w_cand;
    logic [PW-1:0]     w_idx;

    assign w_cand = i_req & ~i_excl;

    // First candidate in search order wins; later hits are ignored
    always_comb begin
        o_win = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (RR == ARB_RR) begin
                w_idx = PW'((int'(i_ptr) + 1 + k) % NPORTS);
            end else begin
                w_idx = PW'(k);
            end
            if (!o_any && w_cand[w_idx]) begin
                o_any        = 1'b1;
                o_win[w_idx] = 1'b1;
                o_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arb_n.sv
// N-port valid/ready memory-bus arbiter with back-to-back handoff
// and an optional watchdog that aborts transfers the slave ignores.
module mem_arb_n
    import mem_arb_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR      = ARB_RR,
    parameter int TIMEOUT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            port_valid,
    output logic [NPORTS-1:0]            port_ready,
    output logic [NPORTS-1:0]            port_err,
    input  logic [NPORTS*ADDR_W-1:0]     port_addr,
    input  logic [NPORTS*DATA_W-1:0]     port_wdata,
    input  logic [NPORTS*(DATA_W/8)-1:0] port_wstrb,
    output logic [DATA_W-1:0]            port_rdata,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [(DATA_W/8)-1:0]        mem_wstrb,
    output logic [NPORTS-1:0]            grant
);

    localparam int SW = DATA_W / 8;
    localparam int PW = $clog2(NPORTS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        r_state;
    logic [NPORTS-1:0] r_grant;
    logic [PW-1:0]     r_gidx;
    logic [PW-1:0]     r_ptr;
    logic [CW-1:0]     r_cnt;

    logic              w_busy;
    logic              w_done;
    logic              w_tout;
    logic              w_end;
    logic [NPORTS-1:0] w_excl;
    logic [NPORTS-1:0] w_win;
    logic [PW-1:0]     w_widx;
    logic              w_any;

    logic [ADDR_W-1:0] w_addr_p [NPORTS];
    logic [DATA_W-1:0] w_data_p [NPORTS];
    logic [SW-1:0]     w_strb_p [NPORTS];

    assign w_busy = (r_state == ST_BUSY);
    assign w_done = w_busy && mem_ready;
    // A late mem_ready on the last allowed cycle still completes normally
    assign w_tout = (TIMEOUT > 0) && w_busy && !mem_ready
                    && (r_cnt == CNT_LAST);
    assign w_end  = w_done || w_tout;

    // The finishing port may not win the very next slot
    assign w_excl = w_busy ? r_grant : '0;

    arb_pick #(
        .NPORTS (NPORTS),
        .RR     (RR),
        .PW     (PW)
    ) u_pick (
        .i_req  (port_valid),
        .i_excl (w_excl),
        .i_ptr  (r_ptr),
        .o_win  (w_win),
        .o_idx  (w_widx),
        .o_any  (w_any)
    );

    genvar g;
    for (g = 0; g < NPORTS; g++) begin : g_slice
        assign w_addr_p[g] = port_addr[slice_lo(g, ADDR_W) +: ADDR_W];
        assign w_data_p[g] = port_wdata[slice_lo(g, DATA_W) +: DATA_W];
        assign w_strb_p[g] = port_wstrb[slice_lo(g, SW) +: SW];
    end

    assign mem_valid  = w_busy;
    assign mem_addr   = w_addr_p[r_gidx];
    assign mem_wdata  = w_data_p[r_gidx];
    assign mem_wstrb  = w_strb_p[r_gidx];
    assign grant      = r_grant;
    assign port_rdata = mem_rdata;
    assign port_ready = r_grant & {NPORTS{mem_ready}};
    assign port_err   = r_grant & {NPORTS{w_tout}};

    // Grant, pointer and watchdog update; grant only moves at transfer end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= PW'(NPORTS - 1);
            r_cnt   <= '0;
        end else if (!w_busy || w_end) begin
            if (w_any) begin
                r_state <= ST_BUSY;
                r_grant <= w_win;
                r_gidx  <= w_widx;
                r_cnt   <= '0;
                if (RR == ARB_RR) begin
                    r_ptr <= w_widx;
                end
            end else begin
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_cnt   <= '0;
            end
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
